// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and op-class helper for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand-side and result-side valid/ready bus of the multi-cycle ALU.
interface alu_mc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [3:0]       control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;

    modport master (
        output in_valid, in1, in2, control, out_ready,
        input  in_ready, out_valid, result, zero, ovf, illegal
    );

    modport slave (
        input  in_valid, in1, in2, control, out_ready,
        output in_ready, out_valid, result, zero, ovf, illegal
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative shift-add multiplier and restoring unsigned divider, one bit per cycle.
// done/res are combinational during the final iteration so the caller can register them.
module alu_muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_mul,
    input  logic             want_rem,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic             active_q, active_d;
    logic             mul_q, mul_d;
    logic             rem_q, rem_d;
    logic [CW-1:0]    count_q, count_d;
    // acc: product or partial remainder; opa: multiplicand or dividend/quotient;
    // opb: multiplier or divisor
    logic [WIDTH-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] acc_step, opa_step, opb_step;

    always_comb begin
        r_shift = {acc_q, opa_q[WIDTH-1]};
        ge      = r_shift >= {1'b0, opb_q};
        diff    = r_shift[WIDTH-1:0] - opb_q;
        if (mul_q) begin
            acc_step = acc_q + (opb_q[0] ? opa_q : '0);
            opa_step = opa_q << 1;
            opb_step = opb_q >> 1;
        end else begin
            // A zero divisor always "fits", giving all-ones quotient and remainder = dividend
            acc_step = ge ? diff : r_shift[WIDTH-1:0];
            opa_step = {opa_q[WIDTH-2:0], ge};
            opb_step = opb_q;
        end
    end

    assign done = active_q && (count_q == CW'(WIDTH - 1));
    assign res  = (mul_q || rem_q) ? acc_step : opa_step;

    always_comb begin
        active_d = active_q;
        mul_d    = mul_q;
        rem_d    = rem_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        if (start) begin
            active_d = 1'b1;
            mul_d    = is_mul;
            rem_d    = want_rem;
            count_d  = '0;
            acc_d    = '0;
            opa_d    = a;
            opb_d    = b;
        end else if (active_q) begin
            acc_d   = acc_step;
            opa_d   = opa_step;
            opb_d   = opb_step;
            count_d = count_q + 1'b1;
            if (done) begin
                active_d = 1'b0;
                count_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            mul_q    <= 1'b0;
            rem_q    <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
        end else begin
            active_q <= active_d;
            mul_q    <= mul_d;
            rem_q    <= rem_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
        end
    end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, single-cycle datapath and registered outputs.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic   clk,
    input logic   rst_n,
    alu_mc_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, illegal_q, illegal_d;

    logic             md_start, md_done;
    logic [WIDTH-1:0] md_res;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf, alu_ill;
    logic [SHW-1:0]   shamt;

    alu_muldiv_seq #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (md_start),
        .is_mul   (bus.control == OP_MUL),
        .want_rem (bus.control == OP_REMU),
        .a        (bus.in1),
        .b        (bus.in2),
        .done     (md_done),
        .res      (md_res)
    );

    assign shamt = bus.in2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (bus.control)
            OP_AND:  alu_res = bus.in1 & bus.in2;
            OP_OR:   alu_res = bus.in1 | bus.in2;
            OP_ADD: begin
                alu_res = bus.in1 + bus.in2;
                alu_ovf = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            OP_XOR:  alu_res = bus.in1 ^ bus.in2;
            OP_NOR:  alu_res = ~(bus.in1 | bus.in2);
            OP_SLL:  alu_res = bus.in1 << shamt;
            OP_SUB: begin
                alu_res = bus.in1 - bus.in2;
                alu_ovf = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.in1) < $signed(bus.in2)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.in1 < bus.in2};
            OP_SRL:  alu_res = bus.in1 >> shamt;
            OP_SRA:  alu_res = $signed(bus.in1) >>> shamt;
            default: alu_ill = !is_multicycle(bus.control);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        md_start  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (is_multicycle(bus.control)) begin
                        md_start = 1'b1;
                        state_d  = BUSY;
                    end else begin
                        state_d   = DONE;
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        ovf_d     = alu_ovf;
                        illegal_d = alu_ill;
                    end
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_d   = DONE;
                    result_d  = md_res;
                    zero_d    = (md_res == '0);
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=32: expectations queued at issue, checked at out_valid.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned SHW = $clog2(W);

    typedef struct packed {
        logic [W-1:0] result;
        logic         zero;
        logic         ovf;
        logic         illegal;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t         e;
        logic [W-1:0] r;
        int           sh;
        sh        = int'(b[SHW-1:0]);
        e.ovf     = 1'b0;
        e.illegal = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                r = a + b;
                e.ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd3:  r = a ^ b;
            4'd4:  r = ~(a | b);
            4'd5:  r = a << sh;
            4'd6: begin
                r = a - b;
                e.ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd7:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd8:  r = (a < b) ? 1 : 0;
            4'd9:  r = a >> sh;
            4'd10: r = $signed(a) >>> sh;
            4'd11: r = a * b;
            4'd12: r = (b == 0) ? '1 : a / b;
            4'd13: r = (b == 0) ? a : a % b;
            default: begin
                r = '0;
                e.illegal = 1'b1;
            end
        endcase
        e.result = r;
        e.zero   = (r == 0);
        return e;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold);
        exp_t e;
        int   lat;
        int   exp_lat;
        exp_lat = (op == 4'd11 || op == 4'd12 || op == 4'd13) ? W + 1 : 1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_before_issue op=%0h: got %b, expected 1", op, bus.in_ready);
        end
        bus.in_valid  = 1'b1;
        bus.in1       = a;
        bus.in2       = b;
        bus.control   = op;
        bus.out_ready = hold;
        sb.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the DUT must use the latched values
        bus.in_valid = 1'b0;
        bus.in1      = ~a;
        bus.in2      = $urandom;
        bus.control  = op ^ 4'h3;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL in_ready_busy op=%0h cycle %0d: got %b, expected 0",
                         op, lat, bus.in_ready);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL latency op=%0h: got %0d, expected %0d", op, lat, exp_lat);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty op=%0h: got 0 entries, expected 1", op);
        end else begin
            e = sb.pop_front();
            checks++;
            if (bus.result !== e.result) begin
                errors++;
                $display("FAIL result op=%0h a=%h b=%h: got %h, expected %h",
                         op, a, b, bus.result, e.result);
            end
            checks++;
            if (bus.zero !== e.zero) begin
                errors++;
                $display("FAIL zero op=%0h: got %b, expected %b", op, bus.zero, e.zero);
            end
            checks++;
            if (bus.ovf !== e.ovf) begin
                errors++;
                $display("FAIL ovf op=%0h: got %b, expected %b", op, bus.ovf, e.ovf);
            end
            checks++;
            if (bus.illegal !== e.illegal) begin
                errors++;
                $display("FAIL illegal op=%0h: got %b, expected %b", op, bus.illegal, e.illegal);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handoff op=%0h: got out_valid=%b in_ready=%b, expected 0 1",
                     op, bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== '0 ||
            bus.zero !== 1'b0 || bus.ovf !== 1'b0 || bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL %s: got rdy=%b vld=%b res=%h z=%b o=%b ill=%b, expected 1 0 0 0 0 0",
                     tag, bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.ovf,
                     bus.illegal);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.control   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_cycle();
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(OP_SUB, 32'd5, 32'd5, 1'b0);
        run_op(OP_SUB, 32'h8000_0000, 32'd1, 1'b0);
        run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(OP_SRA, 32'h8000_0000, 32'd4, 1'b0);
        run_op(OP_SRL, 32'h8000_0000, 32'hFFFF_FF24, 1'b0);
        run_op(OP_SLL, 32'h0000_0003, 32'd31, 1'b0);
        run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
        run_op(OP_OR, 32'hF000_0000, 32'h0000_000F, 1'b0);
        run_op(OP_XOR, 32'hAAAA_5555, 32'hAAAA_5555, 1'b0);
        run_op(OP_NOR, 32'h0000_0000, 32'h0000_0000, 1'b0);
    endtask

    task automatic test_muldiv();
        run_op(OP_MUL, 32'h0000_FFFF, 32'h0001_0001, 1'b0);
        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0);
        run_op(OP_REMU, 32'd100, 32'd7, 1'b0);
        run_op(OP_DIVU, 32'd9, 32'd0, 1'b0);
        run_op(OP_REMU, 32'd9, 32'd0, 1'b0);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    endtask

    task automatic test_backpressure();
        exp_t e;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in1       = 32'h1234_5678;
        bus.in2       = 32'h0F0F_0F0F;
        bus.control   = OP_XOR;
        bus.out_ready = 1'b0;
        sb.push_back(model(OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F));
        @(posedge clk);
        #1;
        // Keep offering a different op while DONE waits; it must be ignored
        bus.in1     = 32'd1;
        bus.in2     = 32'd2;
        bus.control = OP_ADD;
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== e.result) begin
                errors++;
                $display("FAIL hold_done cycle %0d: got vld=%b rdy=%b res=%h, expected 1 0 %h",
                         i, bus.out_valid, bus.in_ready, bus.result, e.result);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_done: got vld=%b rdy=%b, expected 0 1",
                     bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL no_stray_accept: got vld=%b rdy=%b, expected 0 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_mul();
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in1      = 32'h0000_0123;
        bus.in2      = 32'h0000_0456;
        bus.control  = OP_MUL;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid_mul");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_MUL, 32'h0000_0123, 32'h0000_0456, 1'b0);
    endtask

    task automatic test_illegal();
        run_op(4'b1111, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0);
        run_op(4'b1110, 32'h0000_0001, 32'h0000_0001, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = (i % 3 == 0) ? W'($urandom_range(0, 40)) : $urandom;
            run_op(op, a, b, 1'b1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_cycle();
        test_muldiv();
        test_backpressure();
        test_reset_mid_mul();
        test_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU: successor to the single-cycle 32-bit ALU in the execute stage. It adds signed/unsigned compare, shifts, xor/nor, iterative multiply and unsigned divide/remainder, with valid/ready handshakes on both sides. Integer ops complete in 1 cycle; mul/div take WIDTH+1 cycles. It sits between operand fetch and writeback of the multi-cycle datapath.

## Interface
- WIDTH, 32, operand/result width (≥4, power of two).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- control  in  4  opcode.
- out_valid  out  1  result registered and held.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0, every op.
- ovf  out  1  signed overflow; add/sub only, else 0.
- illegal  out  1  unknown opcode; result 0.

## Operation
- Opcodes: 0000 and, 0001 or, 0010 add, 0011 xor, 0100 nor, 0101 sll, 0110 sub, 0111 slt (signed), 1000 sltu, 1001 srl, 1010 sra, 1011 mul (low WIDTH bits), 1100 divu, 1101 remu; 1110/1111 illegal.
- Shift amount = in2[$clog2(WIDTH)-1:0]; upper bits ignored.
- add/sub wrap mod 2^WIDTH; ovf = operand signs agree (sub: A and ~B) and result sign differs.
- slt/sltu return 1 or 0, zero-extended.
- mul: shift-add, one bit of in2 per cycle, WIDTH iterations.
- divu/remu: restoring, one quotient bit per cycle, WIDTH iterations. Divide by zero: quotient all ones, remainder = in1; no flag.
- FSM: IDLE -(accept, 1-cycle op)-> DONE; IDLE -(accept, mul/div)-> BUSY; BUSY -(count == WIDTH-1)-> DONE; DONE -(out_ready)-> IDLE.
- Accept = in_valid && in_ready; operands and opcode latched at accept; input changes afterwards ignored.
- result/zero/ovf/illegal stable throughout DONE until out_ready.

## Timing
- Reset: state IDLE, in_ready 1, out_valid 0, result 0, zero 0, ovf 0, illegal 0, counter 0.
- 1-cycle op accepted at edge N: out_valid high after edge N+1 cycle, i.e. visible in cycle N+1.
- mul/div accepted at edge N: out_valid in cycle N+WIDTH+1.
- out_valid && out_ready at edge M: out_valid low, in_ready high in cycle M+1. No accept in the same cycle as a handoff (no overlap; max throughput 1 op / 2 cycles).
- out_ready held high: result consumed on first out_valid cycle.
- rst_n asserted mid-BUSY or DONE: immediate return to reset values, in-flight op discarded.
- illegal opcode follows 1-cycle path.

## Structure
- Package alu_pkg: 4-bit opcode localparams (OP_AND … OP_REMU), state enum (IDLE, BUSY, DONE), function is_multicycle(op).
- Sub-module alu_muldiv_seq: WIDTH-parametrised iterative mul/divu/remu engine with start/done, owns counter and partial-product/remainder registers; alu_mc holds FSM, 1-cycle datapath, output registers.

## Test plan
- WIDTH=32, add 0x7FFFFFFF+1 -> result 0x80000000, ovf 1, zero 0, out_valid one cycle after accept.
- sub 5-5 -> result 0, zero 1, ovf 0; slt 0xFFFFFFFF,1 -> 1; sltu same -> 0; sra 0x80000000 by 4 -> 0xF8000000.
- mul 0xFFFF*0x10001 -> 0xFFFFFFFF, out_valid exactly 33 cycles after accept, in_ready low throughout.
- divu 100/7 -> 14, remu -> 2; divu 9/0 -> 0xFFFFFFFF, remu 9/0 -> 9.
- out_ready held low 10 cycles in DONE -> result stable, in_ready low, new in_valid ignored; then out_ready -> IDLE next cycle.
- rst_n low mid-mul at iteration 12 -> all outputs reset values asynchronously; next op after release completes correctly; control 1111 -> illegal 1, result 0.
